hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It decides each cycle whether the PC and IF/ID register hold, whether IF/ID is flushed, and whether ID/EX loads a bubble instead of the decoded instruction. Hazards handled: load-use, taken branch resolved in ID, and multi-cycle multiply/divide (MDU) occupancy. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: ID/EX hazard sources in,
// sequencing controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_branch_taken;
  logic             id_mdu_start;
  logic [4:0]       ex_td;
  logic             ex_LW;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken, id_mdu_start,
           ex_td, ex_LW,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch_taken, id_mdu_start,
           ex_td, ex_LW,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS pipeline sequencing: load-use stall, ID branch flush, MDU occupancy
// stall, plus saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int MW = $clog2(MDU_LAT);
  localparam logic [MW-1:0] MDU_LOAD = MW'(MDU_LAT - 1);

  typedef enum logic {
    RUN,
    MDU_WAIT
  } state_t;

  state_t           state;
  logic [MW-1:0]    mdu_cnt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic load_use;
  logic stall;
  logic flush;
  logic busy;

  // A load into $0 never produces a usable value, so it can never be a hazard.
  assign load_use = bus.ex_LW && (bus.ex_td != 5'd0) &&
                    ((bus.id_use_rs && (bus.id_rs == bus.ex_td)) ||
                     (bus.id_use_rt && (bus.id_rt == bus.ex_td)));

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    busy  = 1'b0;
    if (!rst) begin
      unique case (state)
        MDU_WAIT: begin
          stall = 1'b1;
          busy  = 1'b1;
        end
        default: begin
          if (load_use)                 stall = 1'b1;
          else if (bus.id_mdu_start)    flush = bus.id_branch_taken;
          else if (bus.id_branch_taken) flush = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_stall    = stall;
  assign bus.ifid_stall  = stall;
  assign bus.idex_bubble = stall;
  assign bus.ifid_flush  = flush;
  assign bus.mdu_busy    = busy;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

  // NOTE: all state here is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mdu_cnt <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;

      unique case (state)
        MDU_WAIT: begin
          mdu_cnt <= mdu_cnt - 1'b1;
          if (mdu_cnt == MW'(1)) state <= RUN;
        end
        default: begin
          if (!load_use && bus.id_mdu_start) begin
            state   <= MDU_WAIT;
            mdu_cnt <= MDU_LOAD;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int BW      = 16;
  localparam int SW      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_td;
  logic       use_rs, use_rt, br, mdu, ex_lw;

  hazard_ctrl_if #(.CNT_W(BW)) bus_a ();
  hazard_ctrl_if #(.CNT_W(SW)) bus_b ();

  assign bus_a.id_rs = id_rs;            assign bus_b.id_rs = id_rs;
  assign bus_a.id_rt = id_rt;            assign bus_b.id_rt = id_rt;
  assign bus_a.id_use_rs = use_rs;       assign bus_b.id_use_rs = use_rs;
  assign bus_a.id_use_rt = use_rt;       assign bus_b.id_use_rt = use_rt;
  assign bus_a.id_branch_taken = br;     assign bus_b.id_branch_taken = br;
  assign bus_a.id_mdu_start = mdu;       assign bus_b.id_mdu_start = mdu;
  assign bus_a.ex_td = ex_td;            assign bus_b.ex_td = ex_td;
  assign bus_a.ex_LW = ex_lw;            assign bus_b.ex_LW = ex_lw;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(BW)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(SW)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, mdu_busy}
  wire [4:0] ctl_a = {bus_a.pc_stall, bus_a.ifid_stall, bus_a.ifid_flush, bus_a.idex_bubble, bus_a.mdu_busy};
  wire [4:0] ctl_b = {bus_b.pc_stall, bus_b.ifid_stall, bus_b.ifid_flush, bus_b.idex_bubble, bus_b.mdu_busy};
  wire [2*BW+2*SW-1:0] cnt_obs = {bus_a.stall_cnt, bus_a.flush_cnt, bus_b.stall_cnt, bus_b.flush_cnt};

  int errors = 0;
  int checks = 0;

  // Reference model: remaining MDU stall cycles and unbounded event totals.
  int m_remain = 0, m_stall = 0, m_flush = 0;
  int n_remain = 0, n_stall = 0, n_flush = 0;
  logic [4:0]          exp_ctl;
  logic [2*BW+2*SW-1:0] exp_cnt;

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic run_cycle(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] td, input logic urs, input logic urt,
                           input logic b, input logic m, input logic lw);
    logic lu, s, f, busy;
    m_remain = n_remain;
    m_stall  = n_stall;
    m_flush  = n_flush;
    @(negedge clk);
    rst = r; id_rs = rs; id_rt = rt; ex_td = td;
    use_rs = urs; use_rt = urt; br = b; mdu = m; ex_lw = lw;
    #1;
    lu = lw && (td != 5'd0) && ((urs && rs == td) || (urt && rt == td));
    s = 1'b0; f = 1'b0;
    busy = !r && (m_remain > 0);
    if (r)                 begin end
    else if (m_remain > 0) s = 1'b1;
    else if (lu)           s = 1'b1;
    else if (m)            f = b;
    else if (b)            f = 1'b1;
    exp_ctl = {s, s, f, s, busy};
    exp_cnt = {BW'(sat(m_stall, BW)), BW'(sat(m_flush, BW)),
               SW'(sat(m_stall, SW)), SW'(sat(m_flush, SW))};
    if (r) begin
      n_remain = 0; n_stall = 0; n_flush = 0;
    end else begin
      if (m_remain > 0)  n_remain = m_remain - 1;
      else if (!lu && m) n_remain = MDU_LAT - 1;
      else               n_remain = 0;
      n_stall = m_stall + int'(s);
      n_flush = m_flush + int'(f);
    end
  endtask

  task automatic idle(input logic r);
    run_cycle(r, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    run_cycle(1'b1, 5'd3, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ctl_a !== 5'b00000 || ctl_b !== 5'b00000) begin
      errors++; $display("FAIL reset_ctl0: got %b/%b want 00000", ctl_a, ctl_b);
    end
    run_cycle(1'b1, 5'd3, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ctl_a !== 5'b00000 || ctl_b !== 5'b00000) begin
      errors++; $display("FAIL reset_ctl1: got %b/%b want 00000", ctl_a, ctl_b);
    end
    checks++;
    if (cnt_obs !== '0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0", cnt_obs);
    end
    idle(1'b0);
    checks++;
    if (ctl_a !== 5'b00000 || cnt_obs !== '0) begin
      errors++; $display("FAIL reset_release: got ctl %b cnt %h want 00000 / 0", ctl_a, cnt_obs);
    end
  endtask

  task automatic test_load_use;
    idle(1'b1);
    run_cycle(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (ctl_a !== 5'b11010) begin
      errors++; $display("FAIL lu_stall: got %b want 11010", ctl_a);
    end
    run_cycle(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl_a !== 5'b00100) begin
      errors++; $display("FAIL lu_then_flush: got %b want 00100", ctl_a);
    end
    idle(1'b0);
    checks++;
    if (ctl_a !== 5'b00000 || bus_a.stall_cnt !== 16'd1 || bus_a.flush_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_counts: got ctl %b stall %0d flush %0d want 00000 1 1",
                         ctl_a, bus_a.stall_cnt, bus_a.flush_cnt);
    end
  endtask

  task automatic test_zero_reg;
    idle(1'b1);
    run_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_a !== 5'b00000) begin
      errors++; $display("FAIL zero_reg: got %b want 00000", ctl_a);
    end
    run_cycle(1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_a !== 5'b00000) begin
      errors++; $display("FAIL unused_rt: got %b want 00000", ctl_a);
    end
    run_cycle(1'b0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ctl_a !== 5'b11010) begin
      errors++; $display("FAIL used_rt: got %b want 11010", ctl_a);
    end
  endtask

  task automatic test_mdu;
    idle(1'b1);
    run_cycle(1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctl_a !== 5'b00000) begin
      errors++; $display("FAIL mdu_issue: got %b want 00000", ctl_a);
    end
    for (int i = 0; i < MDU_LAT - 1; i++) begin
      run_cycle(1'b0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      checks++;
      if (ctl_a !== 5'b11011) begin
        errors++; $display("FAIL mdu_wait%0d: got %b want 11011", i, ctl_a);
      end
    end
    idle(1'b0);
    checks++;
    if (ctl_a !== 5'b00000 || bus_a.stall_cnt !== 16'd3 || bus_a.flush_cnt !== 16'd0) begin
      errors++; $display("FAIL mdu_done: got ctl %b stall %0d flush %0d want 00000 3 0",
                         ctl_a, bus_a.stall_cnt, bus_a.flush_cnt);
    end
  endtask

  task automatic test_reset_mid_mdu;
    idle(1'b1);
    run_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    checks++;
    if (ctl_a !== 5'b11011) begin
      errors++; $display("FAIL mid_wait1: got %b want 11011", ctl_a);
    end
    idle(1'b1);
    checks++;
    if (ctl_a !== 5'b00000) begin
      errors++; $display("FAIL mid_rst: got %b want 00000", ctl_a);
    end
    idle(1'b0);
    checks++;
    if (ctl_a !== 5'b00000 || cnt_obs !== '0) begin
      errors++; $display("FAIL mid_after: got ctl %b cnt %h want 00000 / 0", ctl_a, cnt_obs);
    end
  endtask

  task automatic test_saturation;
    idle(1'b1);
    for (int i = 0; i < 20; i++)
      run_cycle(1'b0, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    checks++;
    if (bus_b.stall_cnt !== 4'd15 || bus_a.stall_cnt !== 16'd20) begin
      errors++; $display("FAIL saturate: got small %0d wide %0d want 15 20",
                         bus_b.stall_cnt, bus_a.stall_cnt);
    end
  endtask

  task automatic test_random;
    int bad = 0;
    idle(1'b1);
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 59) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 2) == 0));
      checks++;
      if (ctl_a !== exp_ctl || ctl_b !== exp_ctl) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_ctl cycle %0d: got %b/%b want %b", i, ctl_a, ctl_b, exp_ctl);
      end
      checks++;
      if (cnt_obs !== exp_cnt) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_cnt cycle %0d: got %h want %h", i, cnt_obs, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; ex_td = '0;
    use_rs = 1'b0; use_rt = 1'b0; br = 1'b0; mdu = 1'b0; ex_lw = 1'b0;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mdu();
    test_reset_mid_mdu();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
